// File: rtl/game_pkg.sv
// Shared definitions for the light-memory game: idle change code, switch
// front-end state encoding and the 25 MHz board timing defaults.
package game_pkg;

  localparam logic [3:0] CHANGE_IDLE = 4'b1111;

  localparam int DEBOUNCE_CYCLES_DEF = 250_000;
  localparam int HOLDOFF_CYCLES_DEF  = 2_500_000;
  localparam int TIMER_W_DEF         = 22;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    SETTLE  = 3'd2,
    EMIT    = 3'd3,
    HOLDOFF = 3'd4
  } sw_state_e;

  // Active-low toggle mask: a 0 marks every switch that differs.
  function automatic logic [3:0] change_code(input logic [3:0] prev_state,
                                             input logic [3:0] next_state);
    return ~(prev_state ^ next_state);
  endfunction

endpackage

// File: rtl/sw_change_encoder_if.sv
// Switch front-end bus: raw switches and enable in, change code and busy out.
interface sw_change_encoder_if;
  logic [3:0] sw;
  logic       enable;
  logic [3:0] change;
  logic       busy;

  modport master (
    output sw,
    output enable,
    input  change,
    input  busy
  );

  modport slave (
    input  sw,
    input  enable,
    output change,
    output busy
  );
endinterface

// File: rtl/sw_sync.sv
// Parameterised two-flop synchroniser for asynchronous level inputs
// (slide switches now, push buttons later).
module sw_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Two metastability-settling stages, cleared together on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sw_change_encoder.sv
// Debounces the four slide switches and reports each settled toggle as a
// one-cycle active-low change code, followed by a hold-off dead time.
module sw_change_encoder
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
  parameter int TIMER_W         = TIMER_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  sw_change_encoder_if.slave  bus
);

  localparam logic [TIMER_W-1:0] INIT_WAIT    = TIMER_W'(2);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLDOFF_LOAD = TIMER_W'(HOLDOFF_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  logic [3:0]         sw_s2;
  sw_state_e          state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [3:0]         base_q;
  logic [3:0]         cand_q;
  logic [3:0]         change_q;
  logic               busy_q;

  sw_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.sw),
    .q_o (sw_s2)
  );

  // Debounce / emit / hold-off sequencer; busy is registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      timer_q  <= INIT_WAIT;
      change_q <= CHANGE_IDLE;
      busy_q   <= 1'b0;
      base_q   <= 4'b0000;
      cand_q   <= 4'b0000;
    end else begin
      change_q <= CHANGE_IDLE;
      busy_q   <= 1'b0;
      case (state_q)
        INIT: begin
          // Power-on switch positions become the baseline, never an event.
          if (timer_q == '0) begin
            base_q  <= sw_s2;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        IDLE: begin
          if (!bus.enable) begin
            base_q <= sw_s2;
          end else if (sw_s2 != base_q) begin
            cand_q  <= sw_s2;
            timer_q <= SETTLE_LOAD;
            state_q <= SETTLE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end

        SETTLE: begin
          if (!bus.enable) begin
            base_q  <= sw_s2;
            state_q <= IDLE;
          end else if (sw_s2 == base_q) begin
            state_q <= IDLE;
          end else if (sw_s2 != cand_q) begin
            cand_q  <= sw_s2;
            timer_q <= SETTLE_LOAD;
            busy_q  <= 1'b1;
          end else if (timer_q == '0) begin
            state_q <= EMIT;
            busy_q  <= 1'b1;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
            busy_q  <= 1'b1;
          end
        end

        EMIT: begin
          change_q <= change_code(base_q, cand_q);
          base_q   <= cand_q;
          timer_q  <= HOLDOFF_LOAD;
          state_q  <= HOLDOFF;
          busy_q   <= 1'b1;
        end

        HOLDOFF: begin
          // Anything flipped during the dead time is folded into the baseline.
          if (!bus.enable || (timer_q == '0)) begin
            base_q  <= sw_s2;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
            busy_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= INIT;
          timer_q <= INIT_WAIT;
        end
      endcase
    end
  end

  assign bus.change = change_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_sw_change_encoder.sv
// Directed bench for sw_change_encoder: stimulus pushes expected change codes
// with their arrival edge; a monitor pops and checks every non-idle cycle.
module tb_sw_change_encoder;

  localparam int DEB  = 4;
  localparam int HOLD = 6;
  localparam logic [3:0] IDLE_CODE = 4'b1111;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   c0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_active = 1'b0;

  sw_change_encoder_if bus();

  sw_change_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLDOFF_CYCLES  (HOLD),
    .TIMER_W         (22)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 'h%0h, required 'h%0h", name, cyc, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new switch state ahead of edge cyc+1; its code lands at edge cyc+8.
  task automatic flip(input logic [3:0] v, input logic [3:0] exp_code);
    exp_t e;
    bus.sw = v;
    e.code = exp_code;
    e.at   = cyc + 8;
    exp_q.push_back(e);
  endtask

  // Monitor: every non-idle cycle must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.change !== IDLE_CODE) begin
        if (prev_active) begin
          checks++;
          failures++;
          $display("FAIL back_to_back at cycle %0d: got %b after a non-idle cycle, required 1111",
                   cyc, bus.change);
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse at cycle %0d: got %b, required 1111", cyc, bus.change);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("pulse_code", int'(bus.change), int'(mon_e.code));
          check_val("pulse_cycle", cyc, mon_e.at);
        end
        prev_active = 1'b1;
      end else begin
        prev_active = 1'b0;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus.sw     = 4'b0101;
    bus.enable = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(50);
    check_val("powerup_busy", int'(bus.busy), 0);

    // Baseline from power-up is 0101: dropping bit0 reports only bit0.
    flip(4'b0100, 4'b1110);
    tick(25);

    // Clean flip 0000 -> 0100 with busy window checks.
    bus.enable = 1'b0;
    bus.sw     = 4'b0000;
    tick(5);
    bus.enable = 1'b1;
    tick(5);
    flip(4'b0100, 4'b1011);
    tick(2);
    check_val("busy_before_settle", int'(bus.busy), 0);
    tick(1);
    check_val("busy_settle_entry", int'(bus.busy), 1);
    tick(10);
    check_val("busy_holdoff_last", int'(bus.busy), 1);
    tick(1);
    check_val("busy_after_holdoff", int'(bus.busy), 0);
    tick(10);

    // Bounce on bit0; one code counted from the final transition.
    bus.sw = 4'b0101;
    tick(2);
    bus.sw = 4'b0100;
    tick(2);
    flip(4'b0101, 4'b1110);
    tick(25);

    // Two-cycle glitch on bit3.
    bus.sw = 4'b1101;
    tick(2);
    bus.sw = 4'b0101;
    tick(1);
    check_val("glitch_settle_busy", int'(bus.busy), 1);
    tick(2);
    check_val("glitch_busy_drop", int'(bus.busy), 0);
    tick(20);

    // Hold-off absorbs a bit2 flip; the next flip uses the updated base.
    c0 = cyc;
    flip(4'b0111, 4'b1101);
    tick(11);
    check_val("holdoff_timing_ref", cyc, c0 + 11);
    bus.sw = 4'b0011;
    tick(20);
    flip(4'b0010, 4'b1110);
    tick(25);

    // Disabled flips are absorbed, and nothing appears on re-enable.
    bus.enable = 1'b0;
    bus.sw     = 4'b0111;
    tick(10);
    check_val("disabled_busy", int'(bus.busy), 0);
    bus.enable = 1'b1;
    tick(25);

    // Reset in the middle of SETTLE drops the event.
    bus.sw = 4'b1111;
    tick(4);
    check_val("settle_before_rst", int'(bus.busy), 1);
    rst = 1'b1;
    tick(1);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_change", int'(bus.change), int'(IDLE_CODE));
    rst = 1'b0;
    tick(30);
    flip(4'b1110, 4'b1110);
    tick(25);

    check_val("pending_expected", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_change_encoder.md
Name: sw_change_encoder

Overview:
- Player-input front end for the light-memory game.
- Synchronises and debounces the four slide switches, then detects which switches toggled.
- Reports each settled toggle as a one-cycle, active-low 4-bit change code on `change`. The game sequencer compares that code against the stored LED pattern.
- Idle code is 4'b1111, which matches the sequencer's "no input" convention; hold-off after each event keeps one physical flip from producing repeated codes.

Parameters:
- DEBOUNCE_CYCLES, 250_000, clocks a new switch state must stay stable before it is accepted (10 ms at 25 MHz).
- HOLDOFF_CYCLES, 2_500_000, dead time after an emitted event; all switch activity is absorbed (0.1 s).
- TIMER_W, 22, timer width; must hold max(DEBOUNCE_CYCLES, HOLDOFF_CYCLES)-1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- sw  in  4  raw asynchronous slide switches.
- enable  in  1  high while the sequencer accepts input; low = absorb all flips.
- change  out  4  one-cycle active-low toggle mask; 4'b1111 when idle.
- busy  out  1  high in SETTLE, EMIT, HOLDOFF.

Behaviour:
- Synchroniser: 2-flop per bit (s1 <= sw, s2 <= s1). Reset clears both to 0.
- Registers:
  - base (4b): last accepted switch state.
  - cand (4b): candidate new state.
  - timer (TIMER_W): shared settle/hold-off counter.
- States: INIT, IDLE, SETTLE, EMIT, HOLDOFF.
- Reset: state=INIT, timer=2, change=4'b1111, busy=0, base=0, cand=0.
- INIT: decrement timer. At timer==0: base<=s2, go IDLE. No event is ever emitted from the power-on switch positions.
- IDLE:
  - enable==0: base<=s2 every cycle.
  - enable==1 and s2!=base: cand<=s2, timer<=DEBOUNCE_CYCLES-1, go SETTLE.
- SETTLE, evaluated in this priority order:
  1. s2==base: return IDLE with no event (glitch).
  2. s2!=cand: cand<=s2, timer reloaded (bounce restarts window).
  3. timer==0: go EMIT.
  4. Otherwise decrement timer.
- EMIT (one cycle):
  - change<=~(cand^base); base<=cand; timer<=HOLDOFF_CYCLES-1; go HOLDOFF.
  - change is registered, so the code is visible for exactly the one cycle after the EMIT edge, then returns to 1111.
  - Several bits may be 0 if several switches settled together; they are reported as one code.
- HOLDOFF:
  - change=1111.
  - Decrement timer. At 0: base<=s2 (absorbs flips made during hold-off), go IDLE.
- enable deasserted in SETTLE or HOLDOFF: go IDLE next edge, base<=s2, no emission. EMIT always completes its single cycle.
- Latency: a clean flip first sampled into s1 at edge k has its change code registered at edge k+DEBOUNCE_CYCLES+3 (k+1 s2, k+2 enter SETTLE, +DEBOUNCE_CYCLES to timer 0, +1 EMIT).
- Exactly one non-1111 cycle per accepted event; never two consecutive non-idle cycles.
- rst asserted in any state: next edge matches the reset values above, and any in-flight event is dropped.
- busy = (state is SETTLE, EMIT or HOLDOFF), registered with the state.

Decomposition:
- Shared package game_pkg:
  - CHANGE_IDLE = 4'b1111, shared with the sequencer and LED logic.
  - State enum {INIT, IDLE, SETTLE, EMIT, HOLDOFF}.
  - Default DEBOUNCE/HOLDOFF constants for the 25 MHz board clock.
- Sub-module sw_sync: parameterised-width 2-flop synchroniser with synchronous reset. Reused later for push buttons.

Test Plan (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=6):
- Power-up: rst 3 cycles with sw=4'b0101, release.
  - change stays 1111 for 50 cycles; base==0101 after INIT.
- Clean flip: enable=1, sw 0000->0100 at edge k, held.
  - change==4'b1011 for exactly one cycle, registered at edge k+7.
  - busy high from edge k+2 through end of HOLDOFF.
- Bounce: sw toggles bit0 0->1->0->1 with 2-cycle gaps, then holds 1.
  - A single change==4'b1110, registered 7 edges after the final transition.
- Glitch: sw bit3 high for 2 cycles, then back.
  - No change pulse; state returns IDLE; busy drops.
- Hold-off absorb: flip bit1 and get its pulse, then flip bit2 3 cycles after the pulse.
  - No second pulse.
  - Next flip after HOLDOFF is measured against the updated base.
- enable / reset interplay:
  - enable=0 while flipping bit0 and bit2: no pulse, and no pulse on re-enable.
  - rst mid-SETTLE: change stays 1111, state INIT.
